// File: rtl/instr_sequencer_pkg.sv
// Shared types for the fetch/execute sequencer: FSM states, next-PC selector
// codes and the reserved HALT instruction encoding.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        HALT  = 3'd4
    } seq_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_TARGET = 2'd2
    } pc_sel_t;

    localparam logic [8:0] HALT_INSTR = 9'h1FF;

endpackage

// File: rtl/instr_sequencer_pc_next_sel.sv
// Combinational next-PC mux: hold, increment (wrapping) or jump/branch target.
module pc_next_sel
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W = 10
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [PC_W-1:0] i_target,
    input  pc_sel_t         i_sel,
    output logic [PC_W-1:0] o_pc_next
);

    always_comb begin
        o_pc_next = i_pc;
        case (i_sel)
            PC_INC:    o_pc_next = i_pc + PC_W'(1);
            PC_TARGET: o_pc_next = i_target;
            default:   o_pc_next = i_pc;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/execute sequencer: owns PC and IR, walks FETCH -> EXEC -> MEM,
// and gates register-file writes and data-memory requests.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W    = 10,
    parameter int MEM_TMO = 15,
    parameter int CNT_W   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [PC_W-1:0]   StartAddr,
    input  logic [8:0]        InstrIn,
    input  logic              Jump,
    input  logic              BranchEn,
    input  logic              BranchTaken,
    input  logic [PC_W-1:0]   Target,
    input  logic              IsMem,
    input  logic              IsLoad,
    input  logic              MemReady,
    output logic [PC_W-1:0]   PC,
    output logic [8:0]        IR,
    output logic              RegWrEn,
    output logic              MemReq,
    output logic              Busy,
    output logic              Done,
    output logic              MemErr,
    output logic [CNT_W-1:0]  RetireCnt
);

    localparam int TMO_W = $clog2(MEM_TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TMO - 1);

    seq_state_t        r_state;
    seq_state_t        w_next_state;
    logic [PC_W-1:0]   r_pc;
    logic [8:0]        r_ir;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_retire_cnt;
    logic [TMO_W-1:0]  r_tmo;

    logic              w_start;
    logic              w_retire;
    logic              w_wr_en;
    logic              w_tmo_hit;
    pc_sel_t           w_pc_sel;
    logic [PC_W-1:0]   w_pc_next;

    assign w_start = Start && (r_state == IDLE || r_state == HALT);

    pc_next_sel #(.PC_W(PC_W)) u_pc_next_sel (
        .i_pc      (r_pc),
        .i_target  (Target),
        .i_sel     (w_pc_sel),
        .o_pc_next (w_pc_next)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= IDLE;
            r_pc         <= '0;
            r_ir         <= '0;
            r_mem_err    <= 1'b0;
            r_retire_cnt <= '0;
            r_tmo        <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start) begin
                r_pc         <= StartAddr;
                r_retire_cnt <= '0;
                r_mem_err    <= 1'b0;
            end else begin
                r_pc <= w_pc_next;
                if (w_retire && r_retire_cnt != {CNT_W{1'b1}})
                    r_retire_cnt <= r_retire_cnt + CNT_W'(1);
                if (w_tmo_hit)
                    r_mem_err <= 1'b1;
            end
            if (r_state == FETCH)
                r_ir <= InstrIn;
            // Counts consecutive MEM cycles without MemReady; clears on any other state.
            if (r_state == MEM && !MemReady)
                r_tmo <= r_tmo + TMO_W'(1);
            else
                r_tmo <= '0;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_pc_sel     = PC_HOLD;
        w_retire     = 1'b0;
        w_wr_en      = 1'b0;
        w_tmo_hit    = 1'b0;
        case (r_state)
            IDLE, HALT: begin
                if (Start) w_next_state = FETCH;
            end
            FETCH: w_next_state = EXEC;
            EXEC: begin
                if (r_ir == HALT_INSTR) begin
                    w_next_state = HALT;
                end else if (IsMem) begin
                    w_next_state = MEM;
                end else begin
                    w_next_state = FETCH;
                    w_retire     = 1'b1;
                    w_wr_en      = !(Jump || BranchEn);
                    if (Jump || (BranchEn && BranchTaken))
                        w_pc_sel = PC_TARGET;
                    else
                        w_pc_sel = PC_INC;
                end
            end
            MEM: begin
                // A late MemReady on the timeout cycle still counts as success.
                if (MemReady) begin
                    w_next_state = FETCH;
                    w_retire     = 1'b1;
                    w_wr_en      = IsLoad;
                    w_pc_sel     = PC_INC;
                end else if (r_tmo == TMO_LAST) begin
                    w_next_state = FETCH;
                    w_retire     = 1'b1;
                    w_tmo_hit    = 1'b1;
                    w_pc_sel     = PC_INC;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        RegWrEn = w_wr_en && !Reset;
        MemReq  = (r_state == MEM);
        Busy    = (r_state != IDLE) && (r_state != HALT);
        Done    = (r_state == HALT);
    end

    assign PC        = r_pc;
    assign IR        = r_ir;
    assign MemErr    = r_mem_err;
    assign RetireCnt = r_retire_cnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small ROM and opcode decoder stand-in.
module tb_instr_sequencer;

    localparam int PC_W  = 10;
    localparam int CNT_W = 16;

    localparam logic [8:0] OP_ADD   = 9'h001;
    localparam logic [8:0] OP_JMP   = 9'h100;
    localparam logic [8:0] OP_BR    = 9'h080;
    localparam logic [8:0] OP_LOAD  = 9'h040;
    localparam logic [8:0] OP_STORE = 9'h020;
    localparam logic [8:0] OP_HALT  = 9'h1FF;

    logic              Clk;
    logic              Reset;
    logic              Start;
    logic [PC_W-1:0]   StartAddr;
    logic [8:0]        InstrIn;
    logic              Jump;
    logic              BranchEn;
    logic              BranchTaken;
    logic [PC_W-1:0]   Target;
    logic              IsMem;
    logic              IsLoad;
    logic              MemReady;
    logic [PC_W-1:0]   PC;
    logic [8:0]        IR;
    logic              RegWrEn;
    logic              MemReq;
    logic              Busy;
    logic              Done;
    logic              MemErr;
    logic [CNT_W-1:0]  RetireCnt;

    logic [8:0] rom [0:(1<<PC_W)-1];
    int n_chk;
    int n_bad;

    instr_sequencer #(.PC_W(PC_W), .MEM_TMO(15), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .InstrIn(InstrIn), .Jump(Jump), .BranchEn(BranchEn),
        .BranchTaken(BranchTaken), .Target(Target), .IsMem(IsMem),
        .IsLoad(IsLoad), .MemReady(MemReady), .PC(PC), .IR(IR),
        .RegWrEn(RegWrEn), .MemReq(MemReq), .Busy(Busy), .Done(Done),
        .MemErr(MemErr), .RetireCnt(RetireCnt)
    );

    // Combinational instruction ROM and a minimal Ctrl decoder driven from IR.
    assign InstrIn  = rom[PC];
    assign Jump     = (IR == OP_JMP);
    assign BranchEn = (IR == OP_BR);
    assign IsMem    = (IR == OP_LOAD) || (IR == OP_STORE);
    assign IsLoad   = (IR == OP_LOAD);

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_at(input logic [PC_W-1:0] addr);
        Start     = 1'b1;
        StartAddr = addr;
        tick();
        Start     = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        for (int i = 0; i < (1 << PC_W); i++) rom[i] = OP_HALT;
        rom[5]    = OP_ADD;   rom[6]    = OP_HALT;
        rom[10'h10] = OP_JMP; rom[10'h20] = OP_HALT;
        rom[10'h30] = OP_BR;  rom[10'h31] = OP_BR;   rom[3] = OP_HALT;
        rom[10'h40] = OP_LOAD; rom[10'h41] = OP_STORE; rom[10'h42] = OP_HALT;
        rom[10'h50] = OP_LOAD; rom[10'h51] = OP_HALT;
        rom[10'h60] = OP_LOAD; rom[10'h61] = OP_HALT;
        rom[10'h70] = OP_LOAD;
        rom[10'h3FF] = OP_ADD; rom[0] = OP_HALT;

        Reset = 1'b1; Start = 1'b0; StartAddr = '0;
        BranchTaken = 1'b0; Target = '0; MemReady = 1'b0;
        tick(); tick();
        check_eq("rst_pc", PC, 0);
        check_eq("rst_ir", IR, 0);
        check_eq("rst_busy", Busy, 0);
        check_eq("rst_done", Done, 0);
        check_eq("rst_memreq", MemReq, 0);
        check_eq("rst_regwr", RegWrEn, 0);
        check_eq("rst_memerr", MemErr, 0);
        check_eq("rst_cnt", RetireCnt, 0);
        Reset = 1'b0;
        tick();
        check_eq("idle_busy", Busy, 0);

        // ADD then HALT from address 5
        start_at(10'd5);
        check_eq("t1_fetch_pc", PC, 5);
        check_eq("t1_fetch_busy", Busy, 1);
        check_eq("t1_fetch_wr", RegWrEn, 0);
        tick();
        check_eq("t1_exec_pc", PC, 5);
        check_eq("t1_exec_ir", IR, OP_ADD);
        check_eq("t1_exec_wr", RegWrEn, 1);
        tick();
        check_eq("t1_fetch2_pc", PC, 6);
        check_eq("t1_fetch2_wr", RegWrEn, 0);
        tick();
        check_eq("t1_exec2_pc", PC, 6);
        check_eq("t1_halt_wr", RegWrEn, 0);
        tick();
        check_eq("t1_done", Done, 1);
        check_eq("t1_busy", Busy, 0);
        check_eq("t1_cnt", RetireCnt, 1);
        check_eq("t1_pc_held", PC, 6);
        MemReady = 1'b1;
        #1;
        check_eq("halt_memrdy_wr", RegWrEn, 0);
        MemReady = 1'b0;

        // Jump to 0x20, restart from HALT
        start_at(10'h10);
        check_eq("t2_done_drop", Done, 0);
        check_eq("t2_cnt_clr", RetireCnt, 0);
        tick();
        Target = 10'h20;
        #1;
        check_eq("t2_jmp_wr", RegWrEn, 0);
        tick();
        check_eq("t2_jmp_pc", PC, 10'h20);
        check_eq("t2_cnt", RetireCnt, 1);
        tick(); tick();
        check_eq("t2_done", Done, 1);

        // Branch not taken, then taken to 3
        start_at(10'h30);
        tick();
        BranchTaken = 1'b0; Target = 10'h3A;
        #1;
        check_eq("t3_br_wr", RegWrEn, 0);
        tick();
        check_eq("t3_nt_pc", PC, 10'h31);
        tick();
        BranchTaken = 1'b1; Target = 10'd3;
        tick();
        check_eq("t3_tk_pc", PC, 3);
        BranchTaken = 1'b0;
        tick(); tick();
        check_eq("t3_done", Done, 1);
        check_eq("t3_cnt", RetireCnt, 2);

        // LOAD with MemReady on the third MEM cycle, then STORE with immediate ready
        start_at(10'h40);
        tick();
        check_eq("t4_exec_req", MemReq, 0);
        check_eq("t4_exec_wr", RegWrEn, 0);
        tick();
        check_eq("t4_mem1_req", MemReq, 1);
        check_eq("t4_mem1_wr", RegWrEn, 0);
        check_eq("t4_mem1_pc", PC, 10'h40);
        tick();
        check_eq("t4_mem2_req", MemReq, 1);
        tick();
        MemReady = 1'b1;
        #1;
        check_eq("t4_mem3_req", MemReq, 1);
        check_eq("t4_mem3_wr", RegWrEn, 1);
        tick();
        MemReady = 1'b0;
        check_eq("t4_after_req", MemReq, 0);
        check_eq("t4_after_pc", PC, 10'h41);
        check_eq("t4_after_cnt", RetireCnt, 1);
        tick(); tick();
        MemReady = 1'b1;
        #1;
        check_eq("t4_store_wr", RegWrEn, 0);
        tick();
        MemReady = 1'b0;
        check_eq("t4_store_pc", PC, 10'h42);
        check_eq("t4_store_cnt", RetireCnt, 2);
        tick(); tick();
        check_eq("t4_done", Done, 1);
        check_eq("t4_memerr", MemErr, 0);

        // LOAD with MemReady never arriving
        start_at(10'h50);
        tick(); tick();
        for (int i = 1; i < 15; i++) begin
            check_eq("t5_wait_req", MemReq, 1);
            check_eq("t5_wait_err", MemErr, 0);
            tick();
        end
        check_eq("t5_last_req", MemReq, 1);
        check_eq("t5_last_wr", RegWrEn, 0);
        tick();
        check_eq("t5_tmo_err", MemErr, 1);
        check_eq("t5_tmo_req", MemReq, 0);
        check_eq("t5_tmo_pc", PC, 10'h51);
        check_eq("t5_tmo_cnt", RetireCnt, 1);
        tick(); tick();
        check_eq("t5_halt_done", Done, 1);
        check_eq("t5_sticky", MemErr, 1);

        // MemReady on the timeout cycle counts as success
        start_at(10'h60);
        check_eq("t5b_err_clr", MemErr, 0);
        tick(); tick();
        for (int i = 1; i < 15; i++) tick();
        MemReady = 1'b1;
        #1;
        check_eq("t5b_late_wr", RegWrEn, 1);
        tick();
        MemReady = 1'b0;
        check_eq("t5b_late_err", MemErr, 0);
        check_eq("t5b_late_pc", PC, 10'h61);
        tick(); tick();

        // Reset asserted in the middle of MEM
        start_at(10'h70);
        tick(); tick();
        check_eq("t6_mem_req", MemReq, 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_eq("t6_rst_req", MemReq, 0);
        check_eq("t6_rst_pc", PC, 0);
        check_eq("t6_rst_busy", Busy, 0);
        check_eq("t6_rst_done", Done, 0);
        tick();
        check_eq("t6_idle_busy", Busy, 0);

        // PC wrap from the last ROM address
        start_at(10'h3FF);
        tick();
        check_eq("t6_wrap_wr", RegWrEn, 1);
        tick();
        check_eq("t6_wrap_pc", PC, 0);
        tick(); tick();
        check_eq("t6_wrap_done", Done, 1);
        check_eq("t6_wrap_cnt", RetireCnt, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
